// File: rtl/axis_pkg.sv
// Shared types and helpers for the axis_arb_mux arbitrating stream multiplexer.
package axis_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } axis_arb_state_t;

  // Round-robin successor of ptr in a ring of n channels.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/axis_arb_mux_if.sv
// Stream bundle for axis_arb_mux: N packed input channels plus one merged output.
interface axis_arb_mux_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4
);
  localparam int unsigned SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] s_data;
  logic [N-1:0]       s_valid;
  logic [N-1:0]       s_last;
  logic [N-1:0]       s_ready;
  logic [WIDTH-1:0]   m_data;
  logic               m_valid;
  logic               m_last;
  logic [SEL_W-1:0]   m_sel;
  logic               m_ready;

  // slave: the mux itself; master: producers and sink around it
  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid, m_last, m_sel
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid, m_last, m_sel
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, with wrap.
module axis_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_req
);

  int unsigned idx;

  // Walk from the farthest candidate back to ptr so the closest requester wins.
  always_comb begin
    gnt_idx = '0;
    idx     = 32'd0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (32'(ptr) + 32'(k)) % N;
      if (req[idx[SEL_W-1:0]]) gnt_idx = idx[SEL_W-1:0];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/axis_arb_mux.sv
// N-to-1 AXI-Stream round-robin mux with registered output stage.
// Define AXIS_ARB_MUX_PKT_LOCK_EN to hold the grant for a whole packet; otherwise arbitrate per beat.
module axis_arb_mux
  import axis_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  axis_arb_mux_if.slave  bus
);

  localparam int unsigned SEL_W = $clog2(N);

  axis_arb_state_t  state;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_pick;
  logic             any_req;
  logic             load;
  logic             end_beat;

  axis_rr_arbiter #(.N(N)) u_arb (
    .req     (bus.s_valid),
    .ptr     (ptr),
    .gnt_idx (rr_pick),
    .any_req (any_req)
  );

  // Only the granted channel may be ready, and only when the output slot frees up.
  always_comb begin
    bus.s_ready = '0;
    if (state == BUSY && (!bus.m_valid || bus.m_ready)) bus.s_ready[grant] = 1'b1;
  end

  assign load = bus.s_valid[grant] && bus.s_ready[grant];

`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
  assign end_beat = load && bus.s_last[grant];
`else
  assign end_beat = load;
`endif

  // Grant FSM; the pointer always lands one past the channel just granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= rr_pick;
            ptr   <= SEL_W'(rr_next(32'(rr_pick), N));
            state <= BUSY;
          end
        end
        BUSY: begin
          if (end_beat) begin
            if (any_req) begin
              grant <= rr_pick;
              ptr   <= SEL_W'(rr_next(32'(rr_pick), N));
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: payload only changes on a load, so it holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      bus.m_sel   <= '0;
    end else if (load) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= bus.s_data[32'(grant)*WIDTH +: WIDTH];
      bus.m_last  <= bus.s_last[grant];
      bus.m_sel   <= grant;
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_arb_mux.sv
// Directed and randomized checks of axis_arb_mux against a packet-level round-robin model.
module tb_axis_arb_mux;

  logic clk;
  logic rst_n;

  axis_arb_mux_if #(.WIDTH(16), .N(4)) bus ();

  axis_arb_mux #(.WIDTH(16), .N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  // Per-channel pending beats {last, data}; expected output {sel, last, data}.
  logic [16:0] chq[4][$];
  logic [18:0] exp_q[$];
  int          hs_sel[$];
  int          cyc, first_mv, last_hs, rmode;
  bit          hold_prev;
  logic [18:0] prev_o;
  bit          pat[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic add_pkt(input int ch, input int len, input int base, input bit rnd);
    for (int k = 0; k < len; k++) begin
      logic [15:0] d;
      d = rnd ? 16'($urandom) : 16'(base + k);
      chq[ch].push_back({(k == len - 1), d});
    end
  endtask

  // Reference: serve channels with pending traffic in round-robin order from channel 0;
  // a turn is one whole packet with grant locking, otherwise one beat.
  task automatic build_expected();
    logic [16:0] tmp[4][$];
    logic [16:0] b;
    int p, c;
    for (int i = 0; i < 4; i++) tmp[i] = chq[i];
    exp_q.delete();
    p = 0;
    while (1) begin
      c = -1;
      for (int k = 3; k >= 0; k--) if (tmp[(p + k) % 4].size() != 0) c = (p + k) % 4;
      if (c < 0) break;
`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
      do begin
        b = tmp[c].pop_front();
        exp_q.push_back({2'(c), b});
      end while (!b[16] && tmp[c].size() != 0);
`else
      b = tmp[c].pop_front();
      exp_q.push_back({2'(c), b});
`endif
      p = (c + 1) % 4;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) chq[i].delete();
    exp_q.delete();
    hs_sel.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    first_mv = -1;
    last_hs = -1;
    hold_prev = 1'b0;
  endtask

  // One cycle: drive at negedge, sample 1 ns later, retire beats the coming edge will take.
  task automatic step(input bit sb);
    logic [18:0] o, e;
    logic [16:0] popped;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (chq[i].size() != 0) begin
        bus.s_valid[i] = 1'b1;
        bus.s_data[i*16 +: 16] = chq[i][0][15:0];
        bus.s_last[i] = chq[i][0][16];
      end else begin
        bus.s_valid[i] = 1'b0;
        bus.s_data[i*16 +: 16] = '0;
        bus.s_last[i] = 1'b0;
      end
    end
    case (rmode)
      0: bus.m_ready = 1'b1;
      1: bus.m_ready = pat[cyc % 6];
      2: bus.m_ready = 1'($urandom_range(0, 1));
      default: bus.m_ready = 1'b0;
    endcase
    #1;
    o = {bus.m_sel, bus.m_last, bus.m_data};
    if (hold_prev) begin
      chk("hold_valid", 32'(bus.m_valid), 32'd1);
      chk("hold_beat", 32'(o), 32'(prev_o));
    end
    chk("s_ready_onehot", 32'($countones(bus.s_ready) <= 1), 32'd1);
    if (bus.m_valid && bus.m_ready) begin
      hs_sel.push_back(int'(bus.m_sel));
      last_hs = cyc;
      if (sb) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        chk("scoreboard", 32'(o), 32'(e));
      end
    end
    if (bus.m_valid && first_mv < 0) first_mv = cyc;
    hold_prev = bus.m_valid && !bus.m_ready;
    prev_o = o;
    for (int i = 0; i < 4; i++)
      if (bus.s_valid[i] && bus.s_ready[i]) popped = chq[i].pop_front();
    cyc++;
  endtask

  task automatic run_traffic(input int mode);
    int n;
    rmode = mode;
    build_expected();
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      step(1'b1);
      n++;
    end
    if (exp_q.size() != 0) chk("timeout_beats_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    rmode = 0;
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;

    // 1. Reset with random inputs, then asynchronous assertion mid-cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.s_valid = 4'($urandom);
      bus.s_last  = 4'($urandom);
      bus.s_data  = 64'({$urandom, $urandom});
      bus.m_ready = 1'($urandom);
      #1;
      chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_m_data", 32'(bus.m_data), 32'd0);
      chk("rst_m_last_sel", 32'({bus.m_last, bus.m_sel}), 32'd0);
      chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
    end
    do_reset();
    add_pkt(1, 3, 'h10, 1'b0);
    rmode = 3;
    repeat (3) step(1'b0);
    chk("pre_async_m_valid", 32'(bus.m_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_m_valid", 32'(bus.m_valid), 32'd0);
    chk("async_s_ready", 32'(bus.s_ready), 32'd0);

    // 2. Single 3-beat packet on channel 2.
    do_reset();
    add_pkt(2, 3, 'hA1, 1'b0);
    run_traffic(0);
    chk("t2_latency", 32'(first_mv), 32'd2);
    chk("t2_back_to_back", 32'(last_hs - first_mv), 32'd2);
    chk("t2_sel", 32'(hs_sel[0]), 32'd2);

`ifdef AXIS_ARB_MUX_PKT_LOCK_EN
    // 3. Fairness: two 2-beat packets per channel, no interleave and no bubbles.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int c = 0; c < 4; c++) add_pkt(c, 2, 'h100 * c + 'h10 * p, 1'b0);
    run_traffic(0);
    for (int k = 0; k < 8; k++) chk("t3_pkt_order", 32'(hs_sel[2*k]), 32'(k % 4));
    chk("t3_no_bubble", 32'(last_hs - first_mv), 32'd15);
`else
    // 5. Beat-level interleave between channels 0 and 1.
    do_reset();
    add_pkt(0, 4, 'h0, 1'b0);
    add_pkt(1, 4, 'h10, 1'b0);
    run_traffic(0);
    for (int k = 0; k < 8; k++) chk("t5_sel_seq", 32'(hs_sel[k]), 32'(k % 2));
    chk("t5_no_bubble", 32'(last_hs - first_mv), 32'd7);
`endif

    // 4. Backpressure pattern on continuous channel-1 traffic.
    do_reset();
    for (int p = 0; p < 3; p++) add_pkt(1, 3, 'h200 + 'h10 * p, 1'b0);
    run_traffic(1);
    chk("t4_beat_count", 32'(hs_sel.size()), 32'd9);

    // 6. Reset mid-packet on channel 3, then channel 0 must win after release.
    do_reset();
    add_pkt(3, 4, 'h300, 1'b0);
    rmode = 0;
    for (int n = 0; n < 20 && chq[3].size() > 2; n++) step(1'b0);
    chk("t6_mid_packet", 32'(chq[3].size()), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_m_valid", 32'(bus.m_valid), 32'd0);
    do_reset();
    add_pkt(3, 4, 'h340, 1'b0);
    add_pkt(0, 2, 'h040, 1'b0);
    run_traffic(0);
    chk("t6_first_sel", 32'(hs_sel[0]), 32'd0);

    // Randomized packets with random downstream readiness.
    for (int it = 0; it < 4; it++) begin
      do_reset();
      for (int c = 0; c < 4; c++) begin
        int npk;
        npk = int'($urandom_range(0, 3));
        for (int p = 0; p < npk; p++) add_pkt(c, int'($urandom_range(1, 4)), 0, 1'b1);
      end
      run_traffic(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
